// File: rtl/i2c_reg_bank.sv
// rtl/i2c_reg_bank.sv - register bank with auto-increment pointer, write protection and clear sweep
module i2c_reg_bank #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned WP_BASE = 128,
    parameter bit          WRAP_EN = 1'b1
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              ptr_ld_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              wr_en_in,
    input  logic              rd_en_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid_out,
    output logic [ADDR_W-1:0] ptr_out,
    output logic              busy_out,
    output logic              err_out
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              sat_q, sat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] next_ptr;
    logic              at_last;
    logic              wp_hit;

    // Effective address and the pointer value an access at it leaves behind.
    always_comb begin
        ea       = ptr_ld_in ? addr_in : ptr_q;
        at_last  = (ea == LAST_ADDR);
        wp_hit   = (32'(ea) >= WP_BASE);
        next_ptr = ea + ONE;
        if (at_last) begin
            next_ptr = WRAP_EN ? '0 : LAST_ADDR;
        end
    end

    // Next-state logic: clear sweep, or one access per cycle at the effective address.
    // sat_q marks a pointer parked at the top by a saturating access, so a
    // further unloaded access there is an overrun and gets flagged.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        sat_d      = sat_q;
        data_d     = data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = cnt_q;
        mem_wdata  = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + ONE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
                if (wr_en_in || rd_en_in || ptr_ld_in) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                if (clr_in) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    ptr_d   = '0;
                    sat_d   = 1'b0;
                end else if (wr_en_in && rd_en_in) begin
                    err_d = 1'b1;
                    if (ptr_ld_in) begin
                        ptr_d = addr_in;
                        sat_d = 1'b0;
                    end
                end else if (wr_en_in || rd_en_in) begin
                    if (wr_en_in) begin
                        if (wp_hit) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = ea;
                            mem_wdata = data_in;
                        end
                    end else begin
                        data_d     = mem[ea];
                        rd_valid_d = 1'b1;
                    end
                    ptr_d = next_ptr;
                    sat_d = at_last && !WRAP_EN;
                    if (sat_q && !ptr_ld_in && at_last && !WRAP_EN) begin
                        err_d = 1'b1;
                    end
                end else if (ptr_ld_in) begin
                    ptr_d = addr_in;
                    sat_d = 1'b0;
                end
            end
        endcase
    end

    // Control and output registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            ptr_q      <= '0;
            sat_q      <= 1'b0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            sat_q      <= sat_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage array with a single write port and no reset, so it can map to block RAM.
    always_ff @(posedge clock_in) begin
        if (!reset_in && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out     = data_q;
    assign rd_valid_out = rd_valid_q;
    assign ptr_out      = ptr_q;
    assign busy_out     = (state_q == ST_CLEAR);
    assign err_out      = err_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb/tb_i2c_reg_bank.sv - self-checking bench for i2c_reg_bank in three configurations
module tb_i2c_reg_bank;

    localparam int N     = 3;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       ptr_ld = 1'b0;
    logic [6:0] addr = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = '0;
    logic       clr = 1'b0;

    logic [N-1:0][7:0] o_data;
    logic [N-1:0][6:0] o_ptr;
    logic [N-1:0]      o_rv;
    logic [N-1:0]      o_busy;
    logic [N-1:0]      o_err;

    int checks = 0;
    int errors = 0;

    // inst0: wrap, no protection; inst1: saturate, no protection; inst2: wrap, protected from 0x70
    i2c_reg_bank #(.DATA_W(8), .ADDR_W(7), .WP_BASE(128), .WRAP_EN(1'b1)) u_wrap (
        .clock_in(clk), .reset_in(reset), .ptr_ld_in(ptr_ld), .addr_in(addr),
        .wr_en_in(wr_en), .rd_en_in(rd_en), .data_in(din), .clr_in(clr),
        .data_out(o_data[0]), .rd_valid_out(o_rv[0]), .ptr_out(o_ptr[0]),
        .busy_out(o_busy[0]), .err_out(o_err[0]));

    i2c_reg_bank #(.DATA_W(8), .ADDR_W(7), .WP_BASE(128), .WRAP_EN(1'b0)) u_sat (
        .clock_in(clk), .reset_in(reset), .ptr_ld_in(ptr_ld), .addr_in(addr),
        .wr_en_in(wr_en), .rd_en_in(rd_en), .data_in(din), .clr_in(clr),
        .data_out(o_data[1]), .rd_valid_out(o_rv[1]), .ptr_out(o_ptr[1]),
        .busy_out(o_busy[1]), .err_out(o_err[1]));

    i2c_reg_bank #(.DATA_W(8), .ADDR_W(7), .WP_BASE(112), .WRAP_EN(1'b1)) u_wp (
        .clock_in(clk), .reset_in(reset), .ptr_ld_in(ptr_ld), .addr_in(addr),
        .wr_en_in(wr_en), .rd_en_in(rd_en), .data_in(din), .clr_in(clr),
        .data_out(o_data[2]), .rd_valid_out(o_rv[2]), .ptr_out(o_ptr[2]),
        .busy_out(o_busy[2]), .err_out(o_err[2]));

    function automatic int wp_of(input int i);
        return (i == 2) ? 112 : 128;
    endfunction

    function automatic bit wrap_of(input int i);
        return (i != 1);
    endfunction

    logic [7:0] m_mem [N][DEPTH];
    logic [7:0] m_data [N];
    logic [6:0] m_ptr [N];
    logic       m_rv [N];
    logic       m_err [N];
    logic       m_sat [N];
    int         m_busy [N];

    task automatic model_step();
        int ea;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_data[i] = '0; m_rv[i] = 1'b0; m_err[i] = 1'b0; m_ptr[i] = '0;
                m_sat[i] = 1'b0; m_busy[i] = DEPTH;
                for (int a = 0; a < DEPTH; a++) m_mem[i][a] = '0;
            end else begin
                m_rv[i] = 1'b0;
                m_err[i] = 1'b0;
                if (m_busy[i] > 0) begin
                    if (wr_en || rd_en || ptr_ld) m_err[i] = 1'b1;
                    m_busy[i]--;
                end else if (clr) begin
                    m_busy[i] = DEPTH; m_ptr[i] = '0; m_sat[i] = 1'b0;
                    for (int a = 0; a < DEPTH; a++) m_mem[i][a] = '0;
                end else begin
                    ea = ptr_ld ? int'(addr) : int'(m_ptr[i]);
                    if (wr_en && rd_en) begin
                        m_err[i] = 1'b1;
                        if (ptr_ld) begin m_ptr[i] = addr; m_sat[i] = 1'b0; end
                    end else if (wr_en || rd_en) begin
                        if (wr_en) begin
                            if (ea < wp_of(i)) m_mem[i][ea] = din;
                            else m_err[i] = 1'b1;
                        end else begin
                            m_data[i] = m_mem[i][ea];
                            m_rv[i] = 1'b1;
                        end
                        if (ea < DEPTH - 1) begin
                            m_ptr[i] = 7'(ea + 1); m_sat[i] = 1'b0;
                        end else if (wrap_of(i)) begin
                            m_ptr[i] = '0;
                        end else begin
                            if (m_sat[i] && !ptr_ld) m_err[i] = 1'b1;
                            m_ptr[i] = 7'(DEPTH - 1); m_sat[i] = 1'b1;
                        end
                    end else if (ptr_ld) begin
                        m_ptr[i] = addr; m_sat[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [6:0] a, input logic w,
                        input logic rd, input logic [7:0] d, input logic c);
        @(negedge clk);
        reset = r; ptr_ld = l; addr = a; wr_en = w; rd_en = rd; din = d; clr = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int busy_cycles;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_busy[i] !== 1'b1 || o_ptr[i] !== 7'h00 || o_data[i] !== 8'h00 || o_rv[i] !== 1'b0 || o_err[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d got busy=%b ptr=%h data=%h rv=%b err=%b need busy=1 ptr=00 data=00 rv=0 err=0",
                         i, o_busy[i], o_ptr[i], o_data[i], o_rv[i], o_err[i]);
            end
        end
        busy_cycles = 1;
        for (int c = 0; c < 200; c++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (o_busy[0] !== 1'b1) break;
            busy_cycles++;
        end
        checks++;
        if (busy_cycles != DEPTH) begin
            errors++;
            $display("FAIL reset_busy_len got %0d need %0d", busy_cycles, DEPTH);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, (k == 0) ? 7'h00 : (k == 1) ? 7'h3F : 7'h7F, 0, 1, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (o_data[i] !== 8'h00 || o_rv[i] !== 1'b1 || o_busy[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_readback k%0d inst%0d got data=%h rv=%b busy=%b need 00 1 0", k, i, o_data[i], o_rv[i], o_busy[i]);
                end
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] pat [3];
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h33;
        step(0, 1, 7'h10, 1, 0, pat[0], 0);
        step(0, 0, 7'h00, 1, 0, pat[1], 0);
        step(0, 0, 7'h00, 1, 0, pat[2], 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_ptr[i] !== 7'h13 || o_err[i] !== 1'b0) begin
                errors++;
                $display("FAIL burst_ptr inst%0d got ptr=%h err=%b need 13 0", i, o_ptr[i], o_err[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(0, (k == 0), 7'h10, 0, 1, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (o_data[i] !== pat[k] || o_rv[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_read k%0d inst%0d got data=%h rv=%b need %h 1", k, i, o_data[i], o_rv[i], pat[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0] p1 [3];
        logic [6:0] p2 [3];
        logic       e1 [3];
        logic       e2 [3];
        logic [7:0] r7f [3];
        logic [7:0] r00 [3];
        p1[0] = 7'h00; p1[1] = 7'h7F; p1[2] = 7'h00;
        p2[0] = 7'h01; p2[1] = 7'h7F; p2[2] = 7'h01;
        e1[0] = 1'b0;  e1[1] = 1'b0;  e1[2] = 1'b1;
        e2[0] = 1'b0;  e2[1] = 1'b1;  e2[2] = 1'b0;
        r7f[0] = 8'h11; r7f[1] = 8'h22; r7f[2] = 8'h00;
        r00[0] = 8'h22; r00[1] = 8'h00; r00[2] = 8'h22;
        step(0, 1, 7'h7F, 1, 0, 8'h11, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_ptr[i] !== p1[i] || o_err[i] !== e1[i]) begin
                errors++;
                $display("FAIL wrap_first inst%0d got ptr=%h err=%b need %h %b", i, o_ptr[i], o_err[i], p1[i], e1[i]);
            end
        end
        step(0, 0, 7'h00, 1, 0, 8'h22, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_ptr[i] !== p2[i] || o_err[i] !== e2[i]) begin
                errors++;
                $display("FAIL wrap_second inst%0d got ptr=%h err=%b need %h %b", i, o_ptr[i], o_err[i], p2[i], e2[i]);
            end
        end
        step(0, 1, 7'h7F, 0, 1, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_data[i] !== r7f[i] || o_err[i] !== 1'b0) begin
                errors++;
                $display("FAIL wrap_read7f inst%0d got data=%h err=%b need %h 0", i, o_data[i], o_err[i], r7f[i]);
            end
        end
        step(0, 1, 7'h00, 0, 1, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_data[i] !== r00[i]) begin
                errors++;
                $display("FAIL wrap_read00 inst%0d got data=%h need %h", i, o_data[i], r00[i]);
            end
        end
    endtask

    task automatic test_protect();
        logic [7:0] r70 [3];
        r70[0] = 8'hEE; r70[1] = 8'hEE; r70[2] = 8'h00;
        step(0, 1, 7'h70, 1, 0, 8'hEE, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_err[i] !== (i == 2) || o_ptr[i] !== 7'h71) begin
                errors++;
                $display("FAIL protect_hit inst%0d got err=%b ptr=%h need %b 71", i, o_err[i], o_ptr[i], (i == 2));
            end
        end
        step(0, 1, 7'h6F, 1, 0, 8'h44, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_err[i] !== 1'b0 || o_ptr[i] !== 7'h70) begin
                errors++;
                $display("FAIL protect_below inst%0d got err=%b ptr=%h need 0 70", i, o_err[i], o_ptr[i]);
            end
        end
        step(0, 1, 7'h70, 0, 1, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_data[i] !== r70[i]) begin
                errors++;
                $display("FAIL protect_read70 inst%0d got %h need %h", i, o_data[i], r70[i]);
            end
        end
        step(0, 1, 7'h6F, 0, 1, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_data[i] !== 8'h44) begin
                errors++;
                $display("FAIL protect_read6f inst%0d got %h need 44", i, o_data[i]);
            end
        end
    endtask

    task automatic test_collision();
        step(0, 1, 7'h05, 1, 0, 8'h5C, 0);
        step(0, 1, 7'h05, 0, 0, 0, 0);
        step(0, 0, 7'h00, 1, 1, 8'h99, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_err[i] !== 1'b1 || o_rv[i] !== 1'b0 || o_ptr[i] !== 7'h05) begin
                errors++;
                $display("FAIL collision inst%0d got err=%b rv=%b ptr=%h need 1 0 05", i, o_err[i], o_rv[i], o_ptr[i]);
            end
        end
        step(0, 0, 7'h00, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_err[i] !== 1'b0 || o_rv[i] !== 1'b0) begin
                errors++;
                $display("FAIL collision_pulse inst%0d got err=%b rv=%b need 0 0", i, o_err[i], o_rv[i]);
            end
        end
        step(0, 0, 7'h00, 0, 1, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_data[i] !== 8'h5C || o_rv[i] !== 1'b1 || o_ptr[i] !== 7'h06) begin
                errors++;
                $display("FAIL collision_keep inst%0d got data=%h rv=%b ptr=%h need 5C 1 06", i, o_data[i], o_rv[i], o_ptr[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 7'h20, 1, 0, 8'h77, 0);
        step(0, 1, 7'h20, 0, 1, 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_data[i] !== 8'h77 || o_rv[i] !== 1'b1) begin
                errors++;
                $display("FAIL raw inst%0d got data=%h rv=%b need 77 1", i, o_data[i], o_rv[i]);
            end
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        step(0, 1, 7'h00, 1, 0, 8'($urandom), 0);
        for (int k = 1; k < 16; k++) step(0, 0, 7'h00, 1, 0, 8'($urandom_range(1, 255)), 0);
        step(0, 0, 7'h00, 1, 0, 8'hFF, 1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_err[i] !== 1'b0 || o_busy[i] !== 1'b1 || o_ptr[i] !== 7'h00 || o_data[i] !== m_data[i]) begin
                errors++;
                $display("FAIL clear_start inst%0d got err=%b busy=%b ptr=%h data=%h need 0 1 00 %h",
                         i, o_err[i], o_busy[i], o_ptr[i], o_data[i], m_data[i]);
            end
        end
        busy_cycles = 1;
        step(0, 0, 7'h00, 1, 0, 8'hEE, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_err[i] !== 1'b1 || o_busy[i] !== 1'b1) begin
                errors++;
                $display("FAIL clear_busy_wr inst%0d got err=%b busy=%b need 1 1", i, o_err[i], o_busy[i]);
            end
        end
        busy_cycles++;
        for (int c = 0; c < 300; c++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (o_busy[0] !== 1'b1) break;
            busy_cycles++;
        end
        checks++;
        if (busy_cycles != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_len got %0d need %0d", busy_cycles, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            step(0, (a == 0), 7'h00, 0, 1, 0, 0);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (o_data[i] !== 8'h00 || o_rv[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_readback a%0h inst%0d got data=%h rv=%b need 00 1", a, i, o_data[i], o_rv[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] a;
        for (int c = 0; c < 3000; c++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'(7'h7C + $urandom_range(0, 3)) : 7'($urandom);
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 2) == 0), a,
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0), 8'($urandom),
                 ($urandom_range(0, 399) == 0));
            for (int i = 0; i < N; i++) begin
                checks++;
                if (o_data[i] !== m_data[i] || o_rv[i] !== m_rv[i] || o_ptr[i] !== m_ptr[i] ||
                    o_err[i] !== m_err[i] || o_busy[i] !== (m_busy[i] > 0)) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d got data=%h rv=%b ptr=%h err=%b busy=%b need %h %b %h %b %b",
                             c, i, o_data[i], o_rv[i], o_ptr[i], o_err[i], o_busy[i],
                             m_data[i], m_rv[i], m_ptr[i], m_err[i], (m_busy[i] > 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_wrap();
        test_protect();
        test_collision();
        test_back_to_back();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
